// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Sequential binary-to-BCD converter (shift-and-add-3).
//               One shift/correct iteration per clock and WIDTH iterations
//               per conversion. The registered result is presented with a
//               one-cycle done pulse.
//               Optional feature macro: BCD_OVERFLOW_EN. When it is defined,
//               inputs above 10^DIGITS-1 saturate to all nines and raise
//               overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W-1:0]   work_shift;
  logic               unused_carry;

  // Add-3 correction on every work digit that is 5 or more
  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_digit
      assign work_adj[4*k +: 4] = (work_q[4*k +: 4] >= 4'd5) ?
                                  (work_q[4*k +: 4] + 4'd3) : work_q[4*k +: 4];
    end
  endgenerate

  // The binary MSB enters work bit 0; the top work bit falls off, which
  // makes the final result bin mod 10^DIGITS
  assign work_shift   = {work_adj[BCD_W-2:0], bin_q[WIDTH-1]};
  assign unused_carry = work_adj[BCD_W-1];

`ifdef BCD_OVERFLOW_EN
  // 10^DIGITS - 1, saturated to 2^WIDTH - 1 when no WIDTH-bit input can exceed it
  function automatic logic [WIDTH+4:0] f_bcd_max();
    logic [WIDTH+4:0] acc;
    logic [WIDTH+4:0] cap;
    cap        = '0;
    cap[WIDTH] = 1'b1;
    acc        = (WIDTH+5)'(1);
    for (int i = 0; i < DIGITS; i++) begin
      acc = acc * (WIDTH+5)'(10);
      if (acc > cap) acc = cap;
    end
    return acc - (WIDTH+5)'(1);
  endfunction

  localparam logic [WIDTH+4:0] C_BCD_MAX_FULL = f_bcd_max();
  localparam logic [WIDTH:0]   C_BCD_MAX      = C_BCD_MAX_FULL[WIDTH:0];

  logic ovf_flag_q, ovf_flag_d;
  logic overflow_q, overflow_d;
`endif

  // Next-state and datapath computation
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
`ifdef BCD_OVERFLOW_EN
    ovf_flag_d = ovf_flag_q;
    overflow_d = overflow_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          bin_d   = bin;
          work_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef BCD_OVERFLOW_EN
          ovf_flag_d = ({1'b0, bin} > C_BCD_MAX);
`endif
        end
      end
      S_SHIFT: begin
        work_d = work_shift;
        bin_d  = bin_q << 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST_ITER) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef BCD_OVERFLOW_EN
          bcd_d      = ovf_flag_q ? {DIGITS{4'h9}} : work_shift;
          overflow_d = ovf_flag_q;
`else
          bcd_d = work_shift;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any conversion and clears the result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
`ifdef BCD_OVERFLOW_EN
      ovf_flag_q <= 1'b0;
      overflow_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
`ifdef BCD_OVERFLOW_EN
      ovf_flag_q <= ovf_flag_d;
      overflow_q <= overflow_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
`ifdef BCD_OVERFLOW_EN
  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd_seq
// Description : Directed self-checking bench for bin_to_bcd_seq
//               (WIDTH=14, DIGITS=4). Expected results follow the build
//               option BCD_OVERFLOW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 14;
  localparam int DIGITS = 4;

`ifdef BCD_OVERFLOW_EN
  localparam logic [15:0] C_EXP_12345 = 16'h9999;
  localparam logic        C_OVF_12345 = 1'b1;
  localparam logic [15:0] C_EXP_16383 = 16'h9999;
  localparam logic        C_OVF_16383 = 1'b1;
`else
  localparam logic [15:0] C_EXP_12345 = 16'h2345;
  localparam logic        C_OVF_12345 = 1'b0;
  localparam logic [15:0] C_EXP_16383 = 16'h6383;
  localparam logic        C_OVF_16383 = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [WIDTH-1:0]  bin;
  logic              busy;
  logic              done;
  logic [4*DIGITS-1:0] bcd;
  logic              overflow;

  int vectors     = 0;
  int miscompares = 0;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reset for two cycles, then confirm a quiet idle output for 20 cycles
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (bcd !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: bcd=%h busy=%b done=%b ovf=%b, required bcd=0000 busy=0 done=0 ovf=0",
                 i, bcd, busy, done, overflow);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // One full conversion with cycle-exact busy/done/latency checks
  task automatic test_convert(input logic [WIDTH-1:0] value,
                              input logic [15:0] exp_bcd,
                              input logic exp_ovf);
    logic [15:0] prev_bcd;
    logic        prev_ovf;
    @(negedge clk);
    start    = 1'b1;
    bin      = value;
    prev_bcd = bcd;
    prev_ovf = overflow;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = WIDTH'($urandom);
    for (int i = 0; i < WIDTH; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0 || bcd !== prev_bcd || overflow !== prev_ovf) begin
        miscompares++;
        $display("FAIL conv_busy[%0d] val=%0d: busy=%b done=%b bcd=%h ovf=%b, required busy=1 done=0 bcd=%h ovf=%b",
                 i, value, busy, done, bcd, overflow, prev_bcd, prev_ovf);
      end
    end
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || bcd !== exp_bcd || overflow !== exp_ovf) begin
      miscompares++;
      $display("FAIL conv_done val=%0d: done=%b busy=%b bcd=%h ovf=%b, required done=1 busy=0 bcd=%h ovf=%b",
               value, done, busy, bcd, overflow, exp_bcd, exp_ovf);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || bcd !== exp_bcd || overflow !== exp_ovf) begin
      miscompares++;
      $display("FAIL conv_hold val=%0d: done=%b bcd=%h ovf=%b, required done=0 bcd=%h ovf=%b",
               value, done, bcd, overflow, exp_bcd, exp_ovf);
    end
  endtask

  // Basic values including both ends of the 4-digit range
  task automatic test_basic();
    test_convert(14'd1234, 16'h1234, 1'b0);
    test_convert(14'd0,    16'h0000, 1'b0);
    test_convert(14'd9999, 16'h9999, 1'b0);
  endtask

  // Out-of-range value, then a normal one must clear overflow
  task automatic test_overflow();
    test_convert(14'd12345, C_EXP_12345, C_OVF_12345);
    test_convert(14'd42,    16'h0042,    1'b0);
  endtask

  // A start pulse during a conversion must be ignored
  task automatic test_start_while_busy();
    int          ndone;
    logic [15:0] done_bcd;
    ndone    = 0;
    done_bcd = '0;
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd500;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    bin   = 14'd777;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        done_bcd = bcd;
      end
    end
    vectors++;
    if (ndone != 1 || done_bcd !== 16'h0500 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_while_busy: dones=%0d bcd=%h busy=%b, required dones=1 bcd=0500 busy=0",
               ndone, done_bcd, busy);
    end
  endtask

  // Start issued in the done cycle must be accepted immediately
  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd16383;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (WIDTH - 1) @(posedge clk);
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b1 || bcd !== C_EXP_16383 || overflow !== C_OVF_16383) begin
      miscompares++;
      $display("FAIL b2b_first: done=%b bcd=%h ovf=%b, required done=1 bcd=%h ovf=%b",
               done, bcd, overflow, C_EXP_16383, C_OVF_16383);
    end
    start = 1'b1;
    bin   = 14'd8;
    @(posedge clk);
    #1 start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    repeat (WIDTH - 1) @(posedge clk);
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || bcd !== 16'h0008 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second: done=%b busy=%b bcd=%h ovf=%b, required done=1 busy=0 bcd=0008 ovf=0",
               done, busy, bcd, overflow);
    end
  endtask

  // Reset during a conversion aborts it and clears the result
  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd4321;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 16'h0000 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_state: busy=%b done=%b bcd=%h ovf=%b, required busy=0 done=0 bcd=0000 ovf=0",
               busy, done, bcd, overflow);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    vectors++;
    if (ndone != 0 || bcd !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: dones=%0d bcd=%h, required dones=0 bcd=0000", ndone, bcd);
    end
    test_convert(14'd4321, 16'h4321, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
